// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, FSM state
// encoding and the two's-complement overflow rule.
package subtractor_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'b00;
    localparam state_t S_RUN  = 2'b01;
    localparam state_t S_DONE = 2'b10;

    // Subtraction overflows only when operand signs differ and the result's
    // sign departs from the minuend's sign.
    function automatic logic sub_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/onebit_full_subtractor.sv
// Combinational one-bit full subtractor: difference and borrow out of x - y - br.
module onebit_full_subtractor (
    input  logic x,
    input  logic y,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    assign d      = x ^ y ^ br_in;
    assign br_out = (~x & y) | (~(x ^ y) & br_in);

endmodule

// File: rtl/serial_subtractor32.sv
// Bit-serial subtractor: one bit per cycle, LSB first, through a single reused
// one-bit full subtractor. Results are registered and held until the next completion.
module serial_subtractor32
    import subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               br_q, br_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic               bit_d;
    logic               bit_br;
    logic               last_bit;

    // Operand registers shift right each RUN cycle, so bit 0 is always the
    // current bit; the sign bits are kept aside for the overflow check.
    onebit_full_subtractor u_fs (
        .x      (a_q[0]),
        .y      (b_q[0]),
        .br_in  (br_q),
        .d      (bit_d),
        .br_out (bit_br)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned
        // and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        br_d    = br_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bit_br;
                res_d = {bit_d, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    diff_d  = {bit_d, res_q[WIDTH-1:1]};
                    bout_d  = bit_br;
                    ovf_d   = sub_overflow(a_msb_q, b_msb_q, bit_d);
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the datapath registers are reset too, so the outputs and the
    // internal borrow read zero immediately when rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            br_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
